bht_local_hist_predictor: RTL



---
 rtl/bht_if.sv | 23 ++
 rtl/bht_local_hist_predictor.sv | 101 ++++++++++
 2 files changed

// File: rtl/bht_if.sv
// Lookup/prediction and training bus between the fetch frontend and the
// local-history branch predictor.
interface bht_if #(
   parameter int VLEN = 32
);
   logic            req_valid_i;
   logic [VLEN-1:0] req_pc_i;
   logic            pred_valid_o;
   logic            pred_taken_o;
   logic            upd_valid_i;
   logic [VLEN-1:0] upd_pc_i;
   logic            upd_taken_i;

   modport master (
      output req_valid_i, req_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
      input  pred_valid_o, pred_taken_o
   );

   modport slave (
      input  req_valid_i, req_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
      output pred_valid_o, pred_taken_o
   );
endinterface

// File: rtl/bht_local_hist_predictor.sv
// Local-history branch predictor: per-entry history register selects one of
// 2^HIST_BITS saturating 2-bit counters; registered prediction, write-first bypass.
module bht_local_hist_predictor #(
   parameter int NR_ENTRIES = 32,
   parameter int HIST_BITS  = 3,
   parameter int VLEN       = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_bp_i,
   bht_if.slave bus
);
   localparam int IDX_W = $clog2(NR_ENTRIES);
   localparam int CTR_N = 1 << HIST_BITS;

   logic                        valid_r [NR_ENTRIES];
   logic [HIST_BITS-1:0]        hist_r  [NR_ENTRIES];
   logic [CTR_N-1:0][1:0]       ctr_r   [NR_ENTRIES];
   logic                        pred_valid_r;
   logic                        pred_taken_r;

   logic [IDX_W-1:0]            upd_idx_s;
   logic [IDX_W-1:0]            req_idx_s;
   logic [HIST_BITS-1:0]        upd_hist_old_s;
   logic [HIST_BITS-1:0]        upd_hist_new_s;
   logic [1:0]                  upd_ctr_new_s;
   logic                        upd_fire_s;
   logic                        look_valid_s;
   logic [1:0]                  look_ctr_s;
   logic                        look_taken_s;
   logic                        pc_unused_s;

   function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
      logic [1:0] r;
      if (taken) begin
         r = (c == 2'd3) ? 2'd3 : c + 2'd1;
      end else begin
         r = (c == 2'd0) ? 2'd0 : c - 2'd1;
      end
      return r;
   endfunction

   assign pc_unused_s = ^{bus.req_pc_i[VLEN-1:IDX_W+1], bus.req_pc_i[0],
                          bus.upd_pc_i[VLEN-1:IDX_W+1], bus.upd_pc_i[0]};

   // Post-update entry state and the lookup result with same-index bypass
   always_comb begin
      upd_idx_s      = bus.upd_pc_i[IDX_W:1];
      req_idx_s      = bus.req_pc_i[IDX_W:1];
      upd_hist_old_s = hist_r[upd_idx_s];
      upd_ctr_new_s  = ctr_step(ctr_r[upd_idx_s][upd_hist_old_s], bus.upd_taken_i);
      // Truncating {hist, taken} keeps the newest HIST_BITS bits, covering HIST_BITS=1 too
      upd_hist_new_s = HIST_BITS'({upd_hist_old_s, bus.upd_taken_i});
      upd_fire_s     = bus.upd_valid_i & ~flush_bp_i;
      look_valid_s   = valid_r[req_idx_s];
      look_ctr_s     = ctr_r[req_idx_s][hist_r[req_idx_s]];
      if (upd_fire_s && (req_idx_s == upd_idx_s)) begin
         look_valid_s = 1'b1;
         if (upd_hist_new_s == upd_hist_old_s) begin
            look_ctr_s = upd_ctr_new_s;
         end else begin
            look_ctr_s = ctr_r[upd_idx_s][upd_hist_new_s];
         end
      end else begin
         look_valid_s = valid_r[req_idx_s];
      end
      look_taken_s = look_valid_s & look_ctr_s[1];
   end

   // Predictor table: clear on reset/flush, otherwise train the addressed entry
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_bp_i) begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            valid_r[i] <= 1'b0;
            hist_r[i]  <= '0;
            ctr_r[i]   <= {CTR_N{2'b01}};
         end
      end else if (bus.upd_valid_i) begin
         valid_r[upd_idx_s]                 <= 1'b1;
         hist_r[upd_idx_s]                  <= upd_hist_new_s;
         ctr_r[upd_idx_s][upd_hist_old_s]   <= upd_ctr_new_s;
      end
   end

   // Registered prediction, valid for exactly the cycle after a request
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_bp_i) begin
         pred_valid_r <= 1'b0;
         pred_taken_r <= 1'b0;
      end else if (bus.req_valid_i) begin
         pred_valid_r <= look_valid_s;
         pred_taken_r <= look_taken_s;
      end else begin
         pred_valid_r <= 1'b0;
         pred_taken_r <= 1'b0;
      end
   end

   assign bus.pred_valid_o = pred_valid_r;
   assign bus.pred_taken_o = pred_taken_r;
endmodule
